// File: rtl/bp_fpga_host_pkg.sv
// Shared host-side NBF definitions: field widths, opcode encoding and packet layout.
package bp_fpga_host_pkg;

  localparam int unsigned nbf_opcode_width_gp = 8;
  localparam int unsigned nbf_addr_width_gp   = 40;
  localparam int unsigned nbf_data_width_gp   = 64;
  localparam int unsigned nbf_width_gp        = nbf_opcode_width_gp + nbf_addr_width_gp + nbf_data_width_gp;
  localparam int unsigned uart_data_bits_gp   = 8;

  typedef enum logic [nbf_opcode_width_gp-1:0] {
    e_nbf_write     = 8'h03,
    e_nbf_read      = 8'h13,
    e_nbf_putchar   = 8'h40,
    e_nbf_core_done = 8'h41,
    e_nbf_error     = 8'h42,
    e_nbf_fence     = 8'hFE,
    e_nbf_finish    = 8'hFF
  } bp_nbf_opcode_e;

  // Opcode sits in the LSBs so it is the first byte on the wire.
  typedef struct packed {
    logic [nbf_data_width_gp-1:0] data;
    logic [nbf_addr_width_gp-1:0] addr;
    bp_nbf_opcode_e               opcode;
  } bp_nbf_s;

  function automatic int unsigned nbf_bytes(input int unsigned ow, input int unsigned aw,
                                            input int unsigned dw);
    return (ow + aw + dw) / 8;
  endfunction

endpackage

// File: rtl/bp_fpga_host_nbf_serializer.sv
// Parallel-in/serial-out stage: takes one NBF packet per handshake and streams it
// to the UART Tx as bytes, opcode first, then address and data LSB-first.
module bp_fpga_host_nbf_serializer
  import bp_fpga_host_pkg::*;
#(
  parameter int unsigned nbf_opcode_width_p = nbf_opcode_width_gp,
  parameter int unsigned nbf_addr_width_p   = nbf_addr_width_gp,
  parameter int unsigned nbf_data_width_p   = nbf_data_width_gp,
  parameter int unsigned uart_data_bits_p   = uart_data_bits_gp,
  localparam int unsigned nbf_width_lp = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [nbf_width_lp-1:0] nbf_i,
  input  logic                    nbf_v_i,
  output logic                    nbf_ready_and_o,
  output logic [7:0]              tx_data_o,
  output logic                    tx_v_o,
  input  logic                    tx_ready_and_i,
  output logic                    busy_o
);

  localparam int unsigned num_bytes_lp = nbf_bytes(nbf_opcode_width_p, nbf_addr_width_p,
                                                   nbf_data_width_p);
  localparam int unsigned cnt_w_lp     = (num_bytes_lp > 1) ? $clog2(num_bytes_lp) : 1;

  if (uart_data_bits_p != 8) begin : g_bad_uart_width
    $error("uart_data_bits_p must be 8");
  end
  if ((nbf_opcode_width_p % 8) != 0 || (nbf_addr_width_p % 8) != 0
      || (nbf_data_width_p % 8) != 0) begin : g_bad_field_width
    $error("NBF field widths must be multiples of 8");
  end

  typedef enum logic {
    E_IDLE,
    E_SEND
  } state_e;

  state_e                         r_state, w_state_n;
  logic [cnt_w_lp-1:0]            r_cnt, w_cnt_n;
  logic [num_bytes_lp-1:0][7:0]   r_pkt, w_pkt_n;
  logic                           w_send;

  // State, byte counter and packet register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= E_IDLE;
      r_cnt   <= '0;
      r_pkt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pkt   <= w_pkt_n;
    end
  end

  // Next-state: capture in IDLE, advance one byte per Tx handshake in SEND
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pkt_n   = r_pkt;
    case (r_state)
      E_IDLE: begin
        if (nbf_v_i) begin
          w_pkt_n   = nbf_i;
          w_cnt_n   = '0;
          w_state_n = E_SEND;
        end
      end
      E_SEND: begin
        if (tx_ready_and_i) begin
          if (r_cnt == cnt_w_lp'(num_bytes_lp - 1)) begin
            w_cnt_n   = '0;
            w_state_n = E_IDLE;
          end else begin
            w_cnt_n = r_cnt + cnt_w_lp'(1);
          end
        end
      end
      default: w_state_n = E_IDLE;
    endcase
  end

  // Outputs decode registered state; reset gating keeps them quiet before the first edge
  // and stops a byte from being handed off in the cycle a mid-packet reset is applied.
  assign w_send          = reset_n_i && (r_state == E_SEND);
  assign nbf_ready_and_o = reset_n_i && (r_state == E_IDLE);
  assign tx_v_o          = w_send;
  assign busy_o          = w_send;
  assign tx_data_o       = w_send ? r_pkt[r_cnt] : 8'h00;

endmodule

// File: tb/tb_bp_fpga_host_nbf_serializer.sv
// Scoreboard bench for the NBF serializer: default 112-bit packets plus a 72-bit variant.
module tb_bp_fpga_host_nbf_serializer;
  import bp_fpga_host_pkg::*;

  localparam int unsigned NW = 112;
  localparam int unsigned AW = 72;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NW-1:0] nbf;
  logic          nbf_v, nbf_ready;
  logic [7:0]    tx_data;
  logic          tx_v, tx_ready, busy;
  logic [AW-1:0] a_nbf;
  logic          a_v, a_ready;
  logic [7:0]    a_tx_data;
  logic          a_tx_v, a_busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         hs_cnt   = 0;
  int         a_hs_cnt = 0;
  int         rdy_mode = 0;
  logic [7:0] q[$];
  logic [7:0] a_q[$];

  always #5 clk = ~clk;

  bp_fpga_host_nbf_serializer u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .nbf_i(nbf), .nbf_v_i(nbf_v),
    .nbf_ready_and_o(nbf_ready), .tx_data_o(tx_data), .tx_v_o(tx_v),
    .tx_ready_and_i(tx_ready), .busy_o(busy)
  );

  bp_fpga_host_nbf_serializer #(.nbf_addr_width_p(32), .nbf_data_width_p(32)) u_alt (
    .clk_i(clk), .reset_n_i(reset_n), .nbf_i(a_nbf), .nbf_v_i(a_v),
    .nbf_ready_and_o(a_ready), .tx_data_o(a_tx_data), .tx_v_o(a_tx_v),
    .tx_ready_and_i(tx_ready), .busy_o(a_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tx ready driver: 0 = always ready, 1 = random ~30% duty, else never ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 9) < 3);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected bytes on each Tx handshake, checks hold rules
  initial begin
    logic       pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (pv && !pr) begin
          check("hold_valid", 64'(tx_v), 64'd1);
          check("hold_data", 64'(tx_data), 64'(pd));
        end
        if (tx_v) check("ready_low_in_send", 64'(nbf_ready), 64'd0);
        if (tx_v && tx_ready) begin
          hs_cnt++;
          if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", tx_data);
          end else check("byte", 64'(tx_data), 64'(q.pop_front()));
        end
        if (a_tx_v && tx_ready) begin
          a_hs_cnt++;
          if (a_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL alt_unexpected_byte: got 0x%0h expected none", a_tx_data);
          end else check("alt_byte", 64'(a_tx_data), 64'(a_q.pop_front()));
        end
      end
      pv = tx_v; pr = tx_ready; pd = tx_data;
    end
  end

  task automatic push_bytes(input logic [7:0] e[14]);
    foreach (e[i]) q.push_back(e[i]);
  endtask

  // Offer one packet, wait for all 14 bytes, confirm ready returns right after the last one
  task automatic run_pkt(input logic [NW-1:0] p, input string name, input int max);
    int base, k;
    base = hs_cnt;
    k = 0;
    while (!nbf_ready && k < 50) begin @(posedge clk); #1; k++; end
    check({name, "_accept_ready"}, 64'(nbf_ready), 64'd1);
    nbf = p; nbf_v = 1'b1;
    @(posedge clk); #1;
    nbf_v = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    for (int c = 0; c < max; c++) begin
      if (hs_cnt - base >= 14) break;
      @(posedge clk); #1;
    end
    check({name, "_handshakes"}, 64'(hs_cnt - base), 64'd14);
    check({name, "_ready_after"}, 64'(nbf_ready), 64'd1);
    @(posedge clk); #1;
    check({name, "_no_extra"}, 64'(hs_cnt - base), 64'd14);
  endtask

  initial begin
    bp_nbf_s    pk_basic, pk_fin, pk_fence;
    logic [7:0] e_basic[14];
    logic [7:0] e_fin[14];
    logic [7:0] e_fence[14];
    logic [7:0] e_alt[9];
    int         base, a_base;

    pk_basic = '{data: 64'h1122334455667788, addr: 40'h00_8000_0000, opcode: e_nbf_write};
    pk_fin   = '{data: 64'h0, addr: 40'h0, opcode: e_nbf_finish};
    pk_fence = '{data: 64'h0, addr: 40'h0, opcode: e_nbf_fence};
    e_basic = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00,
                8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    e_fin   = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    e_fence = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    e_alt   = '{8'h13, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset held with valid and ready asserted: nothing may be accepted or driven
    reset_n = 1'b0; nbf = pk_basic; nbf_v = 1'b1; tx_ready = 1'b1;
    a_nbf = '0; a_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_ready", 64'(nbf_ready), 64'd0);
      check("rst_tx_v", 64'(tx_v), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'h00);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_alt_ready", 64'(a_ready), 64'd0);
    end
    nbf_v = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(nbf_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_tx_data", 64'(tx_data), 64'h00);

    // Basic packet, Tx always ready
    push_bytes(e_basic);
    run_pkt(pk_basic, "basic", 100);

    // Same packet under random backpressure
    rdy_mode = 1;
    push_bytes(e_basic);
    run_pkt(pk_basic, "bp", 600);
    rdy_mode = 0;

    // Back-to-back: valid held high across two packets
    push_bytes(e_fin);
    push_bytes(e_fence);
    base = hs_cnt;
    nbf = pk_fin; nbf_v = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_busy", 64'(busy), 64'd1);
    nbf = pk_fence;
    for (int c = 0; c < 100; c++) begin
      if (hs_cnt - base >= 14) break;
      @(posedge clk); #1;
    end
    check("b2b_first_count", 64'(hs_cnt - base), 64'd14);
    check("b2b_idle_ready", 64'(nbf_ready), 64'd1);
    check("b2b_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("b2b_second_busy", 64'(busy), 64'd1);
    check("b2b_second_ready", 64'(nbf_ready), 64'd0);
    nbf_v = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (hs_cnt - base >= 28) break;
      @(posedge clk); #1;
    end
    check("b2b_total_count", 64'(hs_cnt - base), 64'd28);
    check("b2b_ready_after", 64'(nbf_ready), 64'd1);

    // Mid-packet reset after the 5th byte handshake
    push_bytes(e_basic);
    base = hs_cnt;
    nbf = pk_basic; nbf_v = 1'b1;
    @(posedge clk); #1;
    nbf_v = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (hs_cnt - base >= 5) break;
      @(posedge clk); #1;
    end
    check("mid_rst_five", 64'(hs_cnt - base), 64'd5);
    reset_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    check("mid_rst_tx_v", 64'(tx_v), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(nbf_ready), 64'd0);
    check("mid_rst_no_more", 64'(hs_cnt - base), 64'd5);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_release_ready", 64'(nbf_ready), 64'd1);
    check("mid_rst_release_tx_v", 64'(tx_v), 64'd0);
    push_bytes(e_fence);
    run_pkt(pk_fence, "after_rst", 100);

    // Narrow variant: 32-bit address and data, 9 bytes
    foreach (e_alt[i]) a_q.push_back(e_alt[i]);
    a_base = a_hs_cnt;
    check("alt_ready", 64'(a_ready), 64'd1);
    a_nbf = {32'h0000_0000, 32'hDEAD_BEEF, 8'h13}; a_v = 1'b1;
    @(posedge clk); #1;
    a_v = 1'b0;
    check("alt_busy", 64'(a_busy), 64'd1);
    for (int c = 0; c < 50; c++) begin
      if (a_hs_cnt - a_base >= 9) break;
      @(posedge clk); #1;
    end
    check("alt_count", 64'(a_hs_cnt - a_base), 64'd9);
    check("alt_ready_after", 64'(a_ready), 64'd1);

    check("queue_empty", 64'(q.size()), 64'd0);
    check("alt_queue_empty", 64'(a_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
